// File: rtl/mac_share_defs.sv
// Shared definitions for the MAC-sharing arbiter: default widths, pipeline
// latency and the one-hot helper used for grants and response strobes.
package mac_share_defs;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_A_W     = 16;
  localparam int DEF_B_W     = 16;
  localparam int DEF_C_W     = 32;
  localparam int DEF_IDX_W   = 2;

  // Cycles from the transfer edge to the response strobe becoming visible.
  localparam int MAC_LATENCY = 2;

  localparam int MAX_REQ   = 8;
  localparam int MAX_IDX_W = 3;

  function automatic logic [MAX_REQ-1:0] onehot_idx(input logic [MAX_IDX_W-1:0] idx);
    logic [MAX_REQ-1:0] oh;
    oh      = {MAX_REQ{1'b0}};
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mac_share_datapath.sv
// Two-stage A*B+C pipeline with requester tag. Kept separate so the MAC
// hard block behind it can be swapped without touching the arbiter.
module mac_share_datapath
  import mac_share_defs::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int A_W     = DEF_A_W,
  parameter int B_W     = DEF_B_W,
  parameter int C_W     = DEF_C_W,
  parameter int IDX_W   = DEF_IDX_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue_valid_i,
  input  logic [IDX_W-1:0]   issue_idx_i,
  input  logic [A_W-1:0]     a_i,
  input  logic [B_W-1:0]     b_i,
  input  logic [C_W-1:0]     c_i,
  output logic               s1_valid_o,
  output logic [NUM_REQ-1:0] rsp_valid_o,
  output logic [C_W-1:0]     rsp_data_o
);

  localparam int PROD_W = A_W + B_W;
  localparam int SUM_W  = (PROD_W > C_W) ? PROD_W : C_W;

  logic               s1_valid_q, s1_valid_d;
  logic [IDX_W-1:0]   s1_idx_q,   s1_idx_d;
  logic [A_W-1:0]     s1_a_q,     s1_a_d;
  logic [B_W-1:0]     s1_b_q,     s1_b_d;
  logic [C_W-1:0]     s1_c_q,     s1_c_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [C_W-1:0]     rsp_data_q,  rsp_data_d;

  logic [PROD_W-1:0]  prod;
  logic [C_W-1:0]     mac_result;

  // Product is formed at full width and zero-extended before the add; the
  // final cast keeps the sum modulo 2^C_W.
  assign prod       = {{B_W{1'b0}}, s1_a_q} * {{A_W{1'b0}}, s1_b_q};
  assign mac_result = C_W'(SUM_W'(prod) + SUM_W'(s1_c_q));

  // Next-state for the operand stage and the result stage
  always_comb begin
    s1_valid_d  = issue_valid_i;
    s1_idx_d    = s1_idx_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_c_d      = s1_c_q;
    rsp_valid_d = {NUM_REQ{1'b0}};
    rsp_data_d  = rsp_data_q;
    if (issue_valid_i) begin
      s1_idx_d = issue_idx_i;
      s1_a_d   = a_i;
      s1_b_d   = b_i;
      s1_c_d   = c_i;
    end else begin
      s1_idx_d = s1_idx_q;
    end
    if (s1_valid_q) begin
      rsp_valid_d = NUM_REQ'(onehot_idx(MAX_IDX_W'(s1_idx_q)));
      rsp_data_d  = mac_result;
    end else begin
      rsp_valid_d = {NUM_REQ{1'b0}};
    end
  end

  // Pipeline registers; reset discards anything in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_idx_q    <= {IDX_W{1'b0}};
      s1_a_q      <= {A_W{1'b0}};
      s1_b_q      <= {B_W{1'b0}};
      s1_c_q      <= {C_W{1'b0}};
      rsp_valid_q <= {NUM_REQ{1'b0}};
      rsp_data_q  <= {C_W{1'b0}};
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_idx_q    <= s1_idx_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_c_q      <= s1_c_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign s1_valid_o  = s1_valid_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: rtl/mac_share_arbiter.sv
// Round-robin front end sharing one multiply-accumulate pipeline among
// NUM_REQ requesters; results return on a one-hot strobe after two cycles.
module mac_share_arbiter
  import mac_share_defs::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int A_W     = DEF_A_W,
  parameter int B_W     = DEF_B_W,
  parameter int C_W     = DEF_C_W,
  parameter int IDX_W   = DEF_IDX_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_en,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  output logic [NUM_REQ-1:0]     o_req_ready,
  input  logic [NUM_REQ*A_W-1:0] i_req_a,
  input  logic [NUM_REQ*B_W-1:0] i_req_b,
  input  logic [NUM_REQ*C_W-1:0] i_req_c,
  output logic [NUM_REQ-1:0]     o_rsp_valid,
  output logic [C_W-1:0]         o_rsp_data,
  output logic                   o_busy
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_found;
  logic             grant_valid;
  logic [A_W-1:0]   sel_a;
  logic [B_W-1:0]   sel_b;
  logic [C_W-1:0]   sel_c;
  logic             s1_valid;

  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    return (sum >= NUM_REQ) ? IDX_W'(sum - NUM_REQ) : IDX_W'(sum);
  endfunction

  // Priority scan from the pointer with wrap; scanning offsets downward lets
  // the nearest valid requester be the last (winning) write.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = {IDX_W{1'b0}};
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req_valid[rr_index(ptr_q, i)]) begin
        grant_found = 1'b1;
        grant_idx   = rr_index(ptr_q, i);
      end else begin
        grant_found = grant_found;
        grant_idx   = grant_idx;
      end
    end
  end

  // Every grant is a transfer because only a valid requester can be picked.
  assign grant_valid = grant_found & i_en & reset;

  // Grant vector, forced low while disabled or in reset
  always_comb begin
    o_req_ready = {NUM_REQ{1'b0}};
    if (grant_valid) begin
      o_req_ready = NUM_REQ'(onehot_idx(MAX_IDX_W'(grant_idx)));
    end else begin
      o_req_ready = {NUM_REQ{1'b0}};
    end
  end

  // Operand mux for the granted requester
  always_comb begin
    sel_a = {A_W{1'b0}};
    sel_b = {B_W{1'b0}};
    sel_c = {C_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == IDX_W'(k)) begin
        sel_a = i_req_a[k*A_W +: A_W];
        sel_b = i_req_b[k*B_W +: B_W];
        sel_c = i_req_c[k*C_W +: C_W];
      end else begin
        sel_a = sel_a;
        sel_b = sel_b;
        sel_c = sel_c;
      end
    end
  end

  // Pointer moves just past the requester that transferred
  always_comb begin
    ptr_d = ptr_q;
    if (grant_valid) begin
      ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : grant_idx + IDX_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= {IDX_W{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

  mac_share_datapath #(
    .NUM_REQ (NUM_REQ),
    .A_W     (A_W),
    .B_W     (B_W),
    .C_W     (C_W),
    .IDX_W   (IDX_W)
  ) u_datapath (
    .clk           (clk),
    .reset         (reset),
    .issue_valid_i (grant_valid),
    .issue_idx_i   (grant_idx),
    .a_i           (sel_a),
    .b_i           (sel_b),
    .c_i           (sel_c),
    .s1_valid_o    (s1_valid),
    .rsp_valid_o   (o_rsp_valid),
    .rsp_data_o    (o_rsp_data)
  );

  assign o_busy = s1_valid | (|o_rsp_valid);

endmodule

// File: doc/mac_share_arbiter.md
Name: mac_share_arbiter

Overview:
- Shares one unsigned 16x16+32 multiply-accumulate datapath among NUM_REQ requesters. Each requester has a valid/ready request channel.
- A round-robin arbiter grants at most one request per cycle. The block registers the operands, computes A*B+C and returns the result to the issuing requester on a one-hot response strobe.
- Sits between the requester engines and a single MAC hard block, so each engine does not need its own MAC.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- A_W, 16, multiplicand width.
- B_W, 16, multiplier width.
- C_W, 32, addend width; also the result width.
- IDX_W, 2, requester index width; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- i_en  input  1  1 = arbitration enabled; 0 = no new grants, in-flight operations drain.
- i_req_valid  input  NUM_REQ  per-requester request valid.
- o_req_ready  output  NUM_REQ  per-requester grant, one-hot or zero.
- i_req_a  input  NUM_REQ*A_W  multiplicands, packed; requester k at [k*A_W +: A_W].
- i_req_b  input  NUM_REQ*B_W  multipliers, packed the same way.
- i_req_c  input  NUM_REQ*C_W  addends, packed the same way.
- o_rsp_valid  output  NUM_REQ  one-hot result strobe, one cycle wide.
- o_rsp_data  output  C_W  result, shared by all requesters.
- o_busy  output  1  1 while any operation is in flight.

Behaviour:
- Reset (reset=0, asynchronous):
  - round-robin pointer = 0;
  - stage valids = 0;
  - o_rsp_valid = 0, o_rsp_data = 0.
  - o_req_ready is forced to 0 while reset is asserted.
  - In-flight operations are discarded and produce no response after release.
- Arbitration (combinational):
  - If i_en=1, grant the first k with i_req_valid[k]=1, scanning from ptr upward with wrap (ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1).
  - o_req_ready = onehot(k). It depends combinationally on i_req_valid, so requesters must not make valid depend on ready.
  - If i_en=0 or no valid is high, o_req_ready = 0.
- Handshake:
  - A transfer occurs for requester k when i_req_valid[k] & o_req_ready[k] are both 1 at the clock edge.
  - A requester holds valid and operands stable until its transfer.
  - Valid may drop without a transfer; no penalty applies.
- Pointer update:
  - On a transfer from k, ptr <= (k+1) mod NUM_REQ.
  - With no transfer, ptr holds.
- Pipeline (fixed 2-cycle latency, one issue per cycle, no stalls):
  - Stage 1, edge of transfer T: register a, b, c, the requester index and s1_valid.
  - Stage 2, edge T+1: o_rsp_data <= (s1_a*s1_b + s1_c) mod 2^C_W, computed unsigned with the product zero-extended. Set o_rsp_valid <= onehot(s1_idx) if s1_valid, else 0.
  - o_rsp_data holds its last value when o_rsp_valid=0.
- Responses have no backpressure; requesters must accept o_rsp_valid when it pulses.
- Responses return in issue order; back-to-back grants give back-to-back responses.
- o_busy = s1_valid | (any bit of o_rsp_valid).
- i_en falling mid-operation: granted operations still complete. Only new grants are blocked.
- Simultaneous requests: exactly one grant per cycle. Over NUM_REQ consecutive busy cycles, every persistently valid requester is granted exactly once (starvation-free).

Decomposition:
- Shared package/include (mac_share_defs): default widths, the fixed latency constant (2), and a onehot-from-index function.
- One natural sub-module, mac_share_datapath:
  - contains the stage-1 operand/tag registers, the A*B+C unit and the stage-2 result registers;
  - is kept separate so the MAC hard block can be swapped.
- The arbiter (pointer plus priority scan) stays in the top module.

Test Plan:
- Single op: req 2 issues a=3, b=5, c=7 at cycle T -> o_rsp_valid=4'b0100, o_rsp_data=22 at T+2; o_busy high T+1..T+2.
- Overflow wrap: a=16'hFFFF, b=16'hFFFF, c=32'h0002_0000 -> o_rsp_data=32'h0000_0001 (value taken mod 2^32).
- Round-robin: all 4 valid for 8 cycles from ptr=0 -> grant order 0,1,2,3,0,1,2,3; 8 responses in the same order, each 2 cycles after its grant.
- Wrap scan: ptr=3, only reqs 1 and 2 valid -> grant 1, then 2, then 1; a lone req 0 is granted the cycle its valid rises.
- i_en drop: grants at T and T+1, i_en=0 from T+2 with all valid -> responses at T+2 and T+3, o_req_ready=0, o_busy falls after T+3.
- Reset mid-flight: grant at T, reset asserted for one cycle between T and T+2 -> no o_rsp_valid pulse, ptr=0, first grant after release goes to req 0 when all are valid.
